regfile_scoreboard: RTL

Parametrised register file for the datapath. It has two combinational read ports with write-through bypass and one synchronous write port with an address separate from the read ports. A per-register busy scoreboard supports multi-cycle producers. A sequential clear engine zeroes the array one entry per cycle without a wide reset fan-out. It replaces the fixed 4x16 file and sits between decode and the ALU/writeback stage.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_ctrl.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the datapath register file.
// Decode and writeback pick up RF_DATA_W / RF_NUM_REGS from here.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 8;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear engine: walks the index counter across every entry
// once, one entry per cycle, holding clr_busy high for NUM_REGS cycles.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = RF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_active,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              clr_we,
    output logic              clr_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    rf_state_e state;

    // Terminal compare stops at the last entry, so the counter never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RF_IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state    <= RF_CLEAR;
                        clr_idx  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state    <= RF_IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign clr_active = (state == RF_CLEAR);
    assign clr_we     = clr_active;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed read ports, one write port, a per-entry
// busy scoreboard for multi-cycle producers and a sequential clear engine.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W,
    parameter  int NUM_REGS = RF_NUM_REGS,
    parameter  bit ZERO_REG = 1'b0,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              rsv_stall
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    logic              clr_active;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_accept;
    logic              rsv_accept;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    regfile_clear_ctrl #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_active (clr_active),
        .clr_idx    (clr_idx),
        .clr_we     (clr_we),
        .clr_busy   (clr_busy)
    );

    // While clearing, writes are dropped and reservations refused outright.
    assign wr_accept  = wr_en && !clr_active && !is_zero_reg(wr_addr);
    assign rsv_accept = rsv_en && !clr_active && !is_zero_reg(rsv_addr);
    assign rsv_stall  = rsv_en && clr_active;

    always_comb begin
        rd_data1  = regs_q[rd_addr1];
        rd_ready1 = !busy_q[rd_addr1];
        if (wr_accept && (wr_addr == rd_addr1)) begin
            rd_data1  = wr_data;
            rd_ready1 = 1'b1;
        end
        if (is_zero_reg(rd_addr1)) begin
            rd_data1  = '0;
            rd_ready1 = 1'b1;
        end

        rd_data2  = regs_q[rd_addr2];
        rd_ready2 = !busy_q[rd_addr2];
        if (wr_accept && (wr_addr == rd_addr2)) begin
            rd_data2  = wr_data;
            rd_ready2 = 1'b1;
        end
        if (is_zero_reg(rd_addr2)) begin
            rd_data2  = '0;
            rd_ready2 = 1'b1;
        end
    end

    // A same-cycle reservation beats the write's busy clear; data still lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_we && (clr_idx == ADDR_W'(i))) begin
                    regs_q[i] <= '0;
                    busy_q[i] <= 1'b0;
                end else begin
                    if (wr_accept && (wr_addr == ADDR_W'(i))) begin
                        regs_q[i] <= wr_data;
                    end
                    if (rsv_accept && (rsv_addr == ADDR_W'(i))) begin
                        busy_q[i] <= 1'b1;
                    end else if (wr_accept && (wr_addr == ADDR_W'(i))) begin
                        busy_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
